// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory loader.
// Holds the bank geometry, the loader state encoding, the byte-lane index
// type and small helpers used by imem_loader and imem_byte_bank.
package imem_pkg;

    localparam int unsigned DEPTH_BYTES = 64;
    localparam int unsigned AW          = 6;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CNT_W       = 5;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    // Byte lane within a 32-bit word (0 = least significant byte)
    typedef logic [1:0] lane_t;

    localparam lane_t LANE_LAST = lane_t'(3);

    // Force a byte address onto a word boundary
    function automatic logic [AW-1:0] align_word(input logic [AW-1:0] a);
        return a & ~AW'(3);
    endfunction

    // Extract one byte lane of a word, little-endian
    function automatic logic [BYTE_W-1:0] lane_byte(input logic [WORD_W-1:0] w,
                                                    input lane_t             l);
        return BYTE_W'(w >> {l, 3'b000});
    endfunction

endpackage

// File: rtl/imem_byte_bank.sv
// Byte-wide instruction bank: one synchronous byte write port and one
// combinational little-endian 32-bit read port whose byte addresses wrap
// modulo DEPTH_BYTES. Contents are never cleared.
//
// Ports:
//   i_clk    clock
//   i_we     byte write enable
//   i_waddr  byte write address
//   i_wdata  byte write data
//   i_raddr  byte read address of the lowest byte
//   o_rdata  {mem[a+3], mem[a+2], mem[a+1], mem[a]} (combinational)
module imem_byte_bank
    import imem_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [BYTE_W-1:0] r_mem [DEPTH_BYTES];

    logic [AW-1:0] w_ra1;
    logic [AW-1:0] w_ra2;
    logic [AW-1:0] w_ra3;

    // AW-bit adds wrap naturally because DEPTH_BYTES == 2**AW
    assign w_ra1 = i_raddr + AW'(1);
    assign w_ra2 = i_raddr + AW'(2);
    assign w_ra3 = i_raddr + AW'(3);

    // Byte write; a same-cycle read still sees the old byte
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = {r_mem[w_ra3], r_mem[w_ra2], r_mem[w_ra1], r_mem[i_raddr]};

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: accepts 32-bit words over valid/ready and
// serialises each into the byte bank, one byte per cycle, little-endian,
// starting at a word-aligned pointer. Also exposes the combinational fetch
// read port of the same bank.
//
// Optional build macro IMEM_LOADER_CHECKSUM_EN: when defined, o_checksum is
// the running XOR of every byte written (cleared by reset and applied start);
// otherwise o_checksum is tied to zero.
//
// Ports:
//   i_clk         clock
//   i_rst_n       synchronous reset, active-low
//   i_start       restart loading at i_start_addr (ignored while writing)
//   i_start_addr  load byte address, bits [AW-1:2] used
//   i_wr_data     instruction word
//   i_wr_valid    i_wr_data valid
//   o_wr_ready    loader can accept a word (combinational on i_start)
//   o_busy        byte serialisation in progress
//   o_full        top of bank reached
//   o_word_count  words stored since reset or start
//   i_address     fetch byte address
//   o_data        fetch data (combinational)
//   o_checksum    running XOR of written bytes, or zero
module imem_loader
    import imem_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [WORD_W-1:0] i_start_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    output logic              o_busy,
    output logic              o_full,
    output logic [CNT_W-1:0]  o_word_count,
    input  logic [WORD_W-1:0] i_address,
    output logic [WORD_W-1:0] o_data,
    output logic [BYTE_W-1:0] o_checksum
);

    state_t             r_state;
    logic [AW-1:0]      r_ptr;
    lane_t              r_bc;
    logic [WORD_W-1:0]  r_word;
    logic               r_busy;
    logic               r_full;
    logic [CNT_W-1:0]   r_count;

    state_t             w_state_nxt;
    logic [AW-1:0]      w_ptr_nxt;
    lane_t              w_bc_nxt;
    logic [WORD_W-1:0]  w_word_nxt;
    logic               w_busy_nxt;
    logic               w_full_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [AW-1:0]      w_ptr_inc;

    logic               w_restart;
    logic               w_we;
    logic [AW-1:0]      w_waddr;
    logic [BYTE_W-1:0]  w_wdata;
    logic               w_unused_bits;

    // Upper address bits fall outside the bank; low start bits are aligned away
    assign w_unused_bits = ^{i_start_addr[WORD_W-1:AW], i_address[WORD_W-1:AW]};

    // Start only takes effect outside WRITE; an in-flight word always completes
    assign w_restart  = i_start & (r_state != ST_WRITE);
    assign o_wr_ready = (r_state == ST_ACCEPT) & ~i_start;

    assign w_waddr = r_ptr + AW'(r_bc);
    assign w_wdata = lane_byte(r_word, r_bc);

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_ACCEPT;
            r_ptr   <= '0;
            r_bc    <= '0;
            r_word  <= '0;
            r_busy  <= 1'b0;
            r_full  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_bc    <= w_bc_nxt;
            r_word  <= w_word_nxt;
            r_busy  <= w_busy_nxt;
            r_full  <= w_full_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state and write-port control
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_bc_nxt    = r_bc;
        w_word_nxt  = r_word;
        w_busy_nxt  = r_busy;
        w_full_nxt  = r_full;
        w_count_nxt = r_count;
        w_we        = 1'b0;
        w_ptr_inc   = r_ptr + AW'(4);

        unique case (r_state)
            ST_ACCEPT: begin
                if (w_restart) begin
                    w_ptr_nxt   = align_word(i_start_addr[AW-1:0]);
                    w_count_nxt = '0;
                    w_full_nxt  = 1'b0;
                end else if (i_wr_valid) begin
                    w_word_nxt  = i_wr_data;
                    w_bc_nxt    = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_we     = 1'b1;
                w_bc_nxt = r_bc + lane_t'(1);
                if (r_bc == LANE_LAST) begin
                    w_ptr_nxt   = w_ptr_inc;
                    w_count_nxt = r_count + CNT_W'(1);
                    w_busy_nxt  = 1'b0;
                    // Pointer wrapping to zero means the top of the bank was written
                    if (w_ptr_inc == '0) begin
                        w_full_nxt  = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else begin
                        w_state_nxt = ST_ACCEPT;
                    end
                end
            end
            ST_FULL: begin
                if (w_restart) begin
                    w_ptr_nxt   = align_word(i_start_addr[AW-1:0]);
                    w_count_nxt = '0;
                    w_full_nxt  = 1'b0;
                    w_state_nxt = ST_ACCEPT;
                end
            end
            default: begin
                w_state_nxt = ST_ACCEPT;
            end
        endcase
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_csum;

    // Running XOR, updated on the same edge as each byte write
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_csum <= '0;
        end else if (w_restart) begin
            r_csum <= '0;
        end else if (w_we) begin
            r_csum <= r_csum ^ w_wdata;
        end
    end

    assign o_checksum = r_csum;
`else
    assign o_checksum = '0;
`endif

    assign o_busy       = r_busy;
    assign o_full       = r_full;
    assign o_word_count = r_count;

    imem_byte_bank u_bank (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (i_address[AW-1:0]),
        .o_rdata (o_data)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed sequences, a vector table
// and randomized traffic, all checked against a byte-queue reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] start_addr;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        busy;
    logic        full;
    logic [4:0]  word_count;
    logic [31:0] address;
    logic [31:0] rd_data;
    logic [7:0]  checksum;

    always #5 clk = ~clk;

    imem_loader dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_start_addr (start_addr),
        .i_wr_data    (wr_data),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .o_busy       (busy),
        .o_full       (full),
        .o_word_count (word_count),
        .i_address    (address),
        .o_data       (rd_data),
        .o_checksum   (checksum)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: pending byte writes, one retired per clock edge
    typedef struct {
        int unsigned addr;
        logic [7:0]  data;
    } bwr_t;

    bwr_t        m_q[$];
    logic [7:0]  m_mem   [64];
    bit          m_known [64];
    int unsigned m_ptr   = 0;
    int unsigned m_count = 0;
    bit          m_full  = 0;
    logic [7:0]  m_csum  = 8'h00;
    bit          m_live  = 0;

    bit          s_ready;
    logic [31:0] s_data;
    bit          last_accept;

    typedef struct {
        logic [31:0] sa;
        logic [31:0] word;
        logic [31:0] rd;
        logic [31:0] exp_data;
        logic        exp_full;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_read(input logic [31:0] ad, output bit ok, output logic [31:0] v);
        int unsigned a;
        ok = 1;
        v  = '0;
        for (int i = 0; i < 4; i++) begin
            a = (int'(ad % 64) + i) % 64;
            if (!m_known[a]) ok = 0;
            v = v | (32'(m_mem[a]) << (8 * i));
        end
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check registers
    task automatic tick(input bit rst, input bit st, input logic [31:0] sa,
                        input bit v, input logic [31:0] wd, input logic [31:0] ad);
        bit          exp_ready;
        bit          was_busy;
        bit          ok;
        logic [31:0] exp_data;
        bwr_t        b;
        rst_n      = rst;
        start      = st;
        start_addr = sa;
        wr_valid   = v;
        wr_data    = wd;
        address    = ad;
        #2;
        s_ready   = wr_ready;
        s_data    = rd_data;
        exp_ready = (m_q.size() == 0) && !m_full && !st;
        if (m_live) begin
            check("wr_ready", 32'(wr_ready), 32'(exp_ready));
            model_read(ad, ok, exp_data);
            if (ok) check("data", rd_data, exp_data);
        end
        @(posedge clk);
        last_accept = 0;
        was_busy    = (m_q.size() != 0);
        if (was_busy) begin
            b = m_q.pop_front();
            m_mem[b.addr]   = b.data;
            m_known[b.addr] = 1;
            m_csum          = m_csum ^ b.data;
            if (m_q.size() == 0 && rst) begin
                m_ptr = (m_ptr + 4) % 64;
                m_count++;
                if (m_ptr == 0) m_full = 1;
            end
        end
        if (!rst) begin
            m_q.delete();
            m_ptr   = 0;
            m_count = 0;
            m_full  = 0;
            m_csum  = 8'h00;
            m_live  = 1;
        end else if (!was_busy) begin
            if (st) begin
                m_ptr   = (int'(sa % 64) / 4) * 4;
                m_count = 0;
                m_full  = 0;
                m_csum  = 8'h00;
            end else if (v && !m_full) begin
                last_accept = 1;
                for (int i = 0; i < 4; i++) begin
                    b.addr = m_ptr + i;
                    b.data = 8'(wd >> (8 * i));
                    m_q.push_back(b);
                end
            end
        end
        #1;
        if (m_live) begin
            check("busy", 32'(busy), 32'(m_q.size() != 0));
            check("full", 32'(full), 32'(m_full));
            check("word_count", 32'(word_count), m_count);
`ifdef IMEM_LOADER_CHECKSUM_EN
            check("checksum", 32'(checksum), 32'(m_csum));
`else
            check("checksum", 32'(checksum), 32'h0);
`endif
        end
    endtask

    task automatic idle(input logic [31:0] ad);
        tick(1, 0, 32'h0, 0, 32'h0, ad);
    endtask

    task automatic do_reset();
        tick(0, 0, 32'h0, 0, 32'h0, 32'h0);
        tick(0, 0, 32'h0, 0, 32'h0, 32'h0);
    endtask

    task automatic do_start(input logic [31:0] sa);
        tick(1, 1, sa, 0, 32'h0, 32'h0);
    endtask

    task automatic handshake(input logic [31:0] w);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick(1, 0, 32'h0, 1, w, 32'h0);
            ok = last_accept;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL handshake_timeout: word %08h not accepted within 50 cycles", w);
        end
    endtask

    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (!busy) break;
            n++;
            idle(32'h0);
        end
    endtask

    task automatic peek(input string name, input logic [31:0] ad, input logic [31:0] exp);
        idle(ad);
        check(name, s_data, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   n;
        int   cyc;
        int   last_cyc;
        int   accepted;
        logic [31:0] exp_ck;

        vecs[0] = '{sa: 32'h0000_0023, word: 32'hDEADBEEF, rd: 32'h20, exp_data: 32'hDEADBEEF, exp_full: 1'b0};
        vecs[1] = '{sa: 32'h0000_0000, word: 32'h8C220004, rd: 32'h00, exp_data: 32'h8C220004, exp_full: 1'b0};
        vecs[2] = '{sa: 32'hFFFF_FF11, word: 32'h12345678, rd: 32'h10, exp_data: 32'h12345678, exp_full: 1'b0};
        vecs[3] = '{sa: 32'h0000_003E, word: 32'hA1B2C3D4, rd: 32'h3C, exp_data: 32'hA1B2C3D4, exp_full: 1'b1};
        vecs[4] = '{sa: 32'h0000_003F, word: 32'h0BADF00D, rd: 32'h3D, exp_data: 32'h040BADF0, exp_full: 1'b1};

        rst_n = 0; start = 0; start_addr = '0; wr_valid = 0; wr_data = '0; address = '0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_count", 32'(word_count), 32'h0);
        idle(32'h0);
        check("rst_ready", 32'(s_ready), 32'h1);

        // First word, valid held high
        handshake(32'h8C220004);
        check("ready_after_hs", 32'(wr_ready), 32'h0);
        drain(n);
        check("busy_cycles", 32'(n), 32'd4);
        check("count_1", 32'(word_count), 32'd1);
        peek("word0", 32'h0, 32'h8C220004);

        // Stream 16 words from a fresh reset
        do_reset();
        accepted = 0;
        last_cyc = 0;
        for (cyc = 0; cyc < 200 && accepted < 16; cyc++) begin
            tick(1, 0, 32'h0, 1, 32'(accepted + 1), 32'h0);
            if (last_accept) begin
                if (accepted > 0) check("accept_gap", 32'(cyc - last_cyc), 32'd5);
                last_cyc = cyc;
                accepted++;
            end
        end
        check("stream_accepted", 32'(accepted), 32'd16);
        drain(n);
        check("stream_full", 32'(full), 32'h1);
        check("stream_count", 32'(word_count), 32'd16);
        for (int i = 0; i < 20; i++) tick(1, 0, 32'h0, 1, 32'h11, 32'h0);
        check("no_17th_ready", 32'(s_ready), 32'h0);
        check("no_17th_count", 32'(word_count), 32'd16);
        peek("stream_top", 32'd60, 32'h00000010);

        // Vector table: start, one word, read back
        for (int k = 0; k < 5; k++) begin
            do_start(vecs[k].sa);
            handshake(vecs[k].word);
            drain(n);
            check("vec_count", 32'(word_count), 32'd1);
            check("vec_full", 32'(full), 32'(vecs[k].exp_full));
            peek("vec_data", vecs[k].rd, vecs[k].exp_data);
        end

        // Start and valid together in ACCEPT: no word taken
        do_start(32'h0);
        tick(1, 1, 32'h0, 1, 32'hCAFEF00D, 32'h0);
        check("start_wins_ready", 32'(s_ready), 32'h0);
        check("start_wins_busy", 32'(busy), 32'h0);

        // Start mid-WRITE is ignored, word completes, next word follows it
        handshake(32'h11112222);
        idle(32'h0);
        tick(1, 1, 32'h30, 0, 32'h0, 32'h0);
        drain(n);
        check("midwrite_count", 32'(word_count), 32'd1);
        handshake(32'h33334444);
        drain(n);
        peek("midwrite_w0", 32'h0, 32'h11112222);
        peek("midwrite_w1", 32'h4, 32'h33334444);

        // Read wrap across top of bank
        do_start(32'd60);
        handshake(32'h22110000);
        drain(n);
        check("wrap_full", 32'(full), 32'h1);
        do_start(32'h0);
        handshake(32'h00004433);
        drain(n);
        peek("read_wrap", 32'd62, 32'h44332211);

        // Checksum after one word
        do_start(32'h0);
        handshake(32'h01020304);
        drain(n);
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_ck = 32'h04;
`else
        exp_ck = 32'h00;
`endif
        check("checksum_word", 32'(checksum), exp_ck);

        // Reset on the second byte edge of a word
        do_start(32'h8);
        handshake(32'hAABBCCDD);
        idle(32'h0);
        tick(0, 0, 32'h0, 0, 32'h0, 32'h0);
        check("rstmid_count", 32'(word_count), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        idle(32'h8);
        check("rstmid_ready", 32'(s_ready), 32'h1);
        check("rstmid_bytes", 32'(s_data[15:0]), 32'h0000CCDD);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom % 300) != 0, ($urandom % 25) == 0, $urandom,
                 ($urandom % 2) == 1, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side counterpart to the instruction memory used by the fetch stage. It accepts 32-bit instruction words over a valid/ready handshake and serialises each word into a 64-byte byte-wide bank, little-endian, one byte per cycle. It also exposes the combinational 32-bit fetch read port, so the CPU fetches from the same bank once loading completes.

Parameters:
DEPTH_BYTES, 64, bank size in bytes; a power of two and a multiple of 4.
AW, 6, byte index width; equals log2(DEPTH_BYTES).

Ports:
Clk  input  1  clock; all state updates on posedge.
Rst  input  1  synchronous reset, active-low.
Start  input  1  one-cycle pulse; restarts loading at StartAddr.
StartAddr  input  32  byte load address; bits [AW-1:2] used, forced word-aligned.
WrData  input  32  instruction word to store.
WrValid  input  1  WrData valid.
WrReady  output  1  loader can accept a word this cycle.
Busy  output  1  byte serialisation in progress.
Full  output  1  top of bank reached; no further words accepted.
WordCount  output  5  words stored since reset or Start.
Address  input  32  fetch byte address.
Data  output  32  {mem[A+3],mem[A+2],mem[A+1],mem[A]}; A = Address mod DEPTH_BYTES.

Behaviour:
- Reset (Rst=0 at posedge): state=ACCEPT, ptr=0, byte counter bc=0, Busy=0, Full=0, WordCount=0. Bank contents are not cleared.
- WrReady = (state==ACCEPT) & ~Start. This is combinational on Start, and Start always wins.
- States are ACCEPT, WRITE and FULL.
- ACCEPT:
  - On WrValid&WrReady, latch WrData into the shift register, set bc=0, go to WRITE, Busy=1.
  - On Start, ptr={StartAddr[AW-1:2],2'b00}, WordCount=0, Full=0, stay in ACCEPT.
- WRITE:
  - Each posedge writes mem[ptr+bc] = word[8*bc+7:8*bc], then bc++.
  - At bc==3 the write completes, ptr+=4 (mod DEPTH_BYTES) and WordCount++.
  - If the new ptr wraps to 0, go to FULL with Full=1; otherwise go to ACCEPT. Busy=0 in both cases.
  - Start is ignored in WRITE; the word always completes.
- Latency and throughput:
  - Handshake at edge N; bytes written at edges N+1..N+4.
  - WrReady high again in the cycle after edge N+4.
  - Throughput is 1 word per 5 cycles.
- FULL: WrReady=0 and WrValid is ignored. Only Start (to ACCEPT, applying StartAddr) or reset exits.
- Start in FULL with StartAddr=60 gives one word, then FULL again.
- WordCount max is 16; it cannot overflow because FULL blocks further words.
- Read port:
  - Purely combinational; address bytes wrap modulo DEPTH_BYTES (A=62 reads bytes 62,63,0,1).
  - A same-cycle read of a byte being written returns the old value; the new value is visible after the edge.
- Reset mid-WRITE abandons the word. Bytes already written remain in the bank, and WordCount returns to 0.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Defined: output Checksum[7:0] carries the running XOR of every byte written. It is cleared by reset and by an applied Start, and updates on the same edge as each byte write.
- Undefined: the Checksum port still exists, tied to 8'h00; no XOR logic.

Decomposition:
- Package imem_pkg holds:
  - DEPTH_BYTES and AW constants.
  - State enum {ACCEPT, WRITE, FULL}.
  - The byte-lane index type.
- Sub-module imem_byte_bank: DEPTH_BYTES x 8 storage, one synchronous byte write port (we, waddr, wdata), and one combinational 4-byte little-endian wrapping read port.
- imem_loader holds the FSM, pointer, counters and handshake.

Test Plan:
- Reset, then send 0x8C220004 with WrValid held high. Expected:
  - WrReady falls after the handshake and Busy=1 for 4 cycles.
  - Reading Address=0 afterwards gives Data=0x8C220004 and mem[0..3]=04,00,22,8C.
  - WordCount=1.
- Stream 16 words, 0x00000001..0x00000010, with WrValid held high:
  - Accept edges are 5 cycles apart.
  - After the 16th word, Full=1, WrReady=0 and WordCount=16.
  - A 17th word is never accepted; Address=60 reads 0x00000010.
- From FULL, pulse Start with StartAddr=0x0000_0023, then send 0xDEADBEEF:
  - ptr aligns to 0x20, so Address=0x20 reads 0xDEADBEEF.
  - WordCount=1 and Full=0.
- In ACCEPT, raise Start and WrValid in the same cycle: WrReady=0 and no word is written. Raise Start mid-WRITE: it is ignored and the word completes.
- Drop Rst at the second byte edge of a word 0xAABBCCDD: state returns to ACCEPT and WordCount=0; mem[ptr]=DD and mem[ptr+1]=CC persist.
- Read wrap: with bytes 62,63,0,1 loaded as 11,22,33,44, Address=62 gives Data=0x44332211.
- With IMEM_LOADER_CHECKSUM_EN, after loading 0x01020304 the Checksum reads 0x04; it is 0x00 when the macro is undefined.
